// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
//   Shared definitions for the IF/MEM bus arbiter: arbiter state encoding,
//   chip/write enable levels, zero word and legacy bus width constants.
package bus_arbiter_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;
  localparam int unsigned DataBus     = 32;

  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [DataBus-1:0] ZeroWord = '0;

  // 2-bit encodings kept identical to the legacy localparam values.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    I_BUSY    = 2'b01,
    D_BUSY    = 2'b10,
    I_DISCARD = 2'b11
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Shares one external memory bus port between instruction fetch (IF,
//   read-only) and data access (MEM, read/write). One transaction at a time
//   over a bus_req/bus_ack handshake; data requests win over fetches.
//   A flush discards an in-flight fetch (the bus cycle still completes).
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   i_ce/i_addr        fetch request (level, held until i_ack) and address
//   i_inst/i_ack       fetched word (held until next i_ack), 1-cycle pulse
//   d_ce/d_we/d_addr/d_wdata/d_sel
//                      data request (level, held until d_ack)
//   d_rdata/d_ack      read data (held until next d_ack), 1-cycle pulse
//   flush              pipeline flush from ctrl
//   stallreq_if/_mem   combinational stall requests to ctrl
//   bus_*              external memory port; bus_rdata sampled with bus_ack
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ce,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_inst,
  output logic          i_ack,
  input  logic          d_ce,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_sel,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  input  logic          flush,
  output logic          stallreq_if,
  output logic          stallreq_mem,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [3:0]    bus_sel,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack
);

  arb_state_e state;

  assign stallreq_if  = i_ce & ~i_ack & ~flush;
  assign stallreq_mem = d_ce & ~d_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= ChipDisable;
      bus_we    <= WriteDisable;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_sel   <= 4'b0000;
      i_inst    <= '0;
      d_rdata   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          // A ce seen together with its own ack belongs to the transaction
          // just completed; it is not re-issued.
          if (d_ce == ChipEnable && !d_ack) begin
            state     <= D_BUSY;
            bus_req   <= ChipEnable;
            bus_we    <= d_we;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
            bus_sel   <= d_sel;
          end else if (i_ce == ChipEnable && !i_ack && !flush) begin
            state    <= I_BUSY;
            bus_req  <= ChipEnable;
            bus_we   <= WriteDisable;
            bus_addr <= i_addr;
            bus_sel  <= 4'b1111;
          end
        end
        I_BUSY: begin
          if (bus_ack) begin
            bus_req <= ChipDisable;
            state   <= IDLE;
            if (!flush) begin
              i_inst <= bus_rdata;
              i_ack  <= 1'b1;
            end
          end else if (flush) begin
            // Bus cycle must still finish; only its result is dropped.
            state <= I_DISCARD;
          end
        end
        I_DISCARD: begin
          if (bus_ack) begin
            bus_req <= ChipDisable;
            state   <= IDLE;
          end
        end
        D_BUSY: begin
          if (bus_ack) begin
            bus_req <= ChipDisable;
            d_ack   <= 1'b1;
            state   <= IDLE;
            if (bus_we != WriteEnable) d_rdata <= bus_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Directed bench for bus_arbiter. A bus responder with programmable wait
//   states feeds read data from a queue; expected acks are pushed to a
//   scoreboard when a request is driven and popped when an ack appears.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_ce = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_inst;
  logic        i_ack;
  logic        d_ce = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_sel = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        flush = 1'b0;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] bus_data_q[$];
  int unsigned wait_cycles = 0;
  int unsigned cnt = 0;
  int          n_iack = 0;
  int          n_dack = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .i_ce(i_ce), .i_addr(i_addr), .i_inst(i_inst), .i_ack(i_ack),
    .d_ce(d_ce), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_sel(d_sel), .d_rdata(d_rdata), .d_ack(d_ack),
    .flush(flush), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack)
  );

  // Bus responder: ack after wait_cycles cycles of bus_req, for one cycle.
  always @(negedge clk) begin
    if (bus_ack) begin
      bus_ack = 1'b0;
      cnt     = 0;
    end else if (bus_req !== 1'b1) begin
      cnt = 0;
    end else if (cnt >= wait_cycles) begin
      bus_ack   = 1'b1;
      bus_rdata = (bus_data_q.size() > 0) ? bus_data_q.pop_front() : 32'h0;
    end else begin
      cnt++;
    end
  end

  always @(negedge clk) begin
    if (i_ack === 1'b1) n_iack++;
    if (d_ack === 1'b1) n_dack++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [31:0] addr, input logic we,
                           input logic [3:0] sel, input bit chk_wd, input logic [31:0] wd);
    chk({tag, ".req"}, {31'b0, bus_req}, 32'd1);
    chk({tag, ".addr"}, bus_addr, addr);
    chk({tag, ".we"}, {31'b0, bus_we}, {31'b0, we});
    chk({tag, ".sel"}, {28'b0, bus_sel}, {28'b0, sel});
    if (chk_wd) chk({tag, ".wdata"}, bus_wdata, wd);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".bus_req"}, {31'b0, bus_req}, 32'd0);
    chk({tag, ".bus_we"}, {31'b0, bus_we}, 32'd0);
    chk({tag, ".bus_addr"}, bus_addr, 32'd0);
    chk({tag, ".bus_wdata"}, bus_wdata, 32'd0);
    chk({tag, ".bus_sel"}, {28'b0, bus_sel}, 32'd0);
    chk({tag, ".i_inst"}, i_inst, 32'd0);
    chk({tag, ".d_rdata"}, d_rdata, 32'd0);
    chk({tag, ".acks"}, {30'b0, i_ack, d_ack}, 32'd0);
  endtask

  // Wait up to 'limit' negedges for an ack, then compare it to the scoreboard.
  task automatic check_ack(input string tag, input int unsigned limit);
    bit   seen = 1'b0;
    exp_t e;
    for (int unsigned k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      seen = (i_ack === 1'b1) || (d_ack === 1'b1);
    end
    vectors++;
    assert (seen) else begin
      miscompares++;
      $error("FAIL %s.ack: observed none expected ack within %0d cycles", tag, limit);
    end
    if (seen) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL %s.sb: observed ack expected none queued", tag);
      end else begin
        e = exp_q.pop_front();
        chk({tag, ".kind"}, {30'b0, d_ack, i_ack}, e.is_d ? 32'd2 : 32'd1);
        chk({tag, ".data"}, e.is_d ? d_rdata : i_inst, e.data);
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  initial begin
    int base_i;
    int base_d;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    chk("reset.stall", {30'b0, stallreq_if, stallreq_mem}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch, minimum latency
    wait_cycles = 0;
    i_ce = 1'b1; i_addr = 32'h0000_0004;
    bus_data_q.push_back(32'h3401_1100);
    exp_q.push_back('{is_d: 1'b0, data: 32'h3401_1100});
    #1 chk("fetch1.stall_c0", {31'b0, stallreq_if}, 32'd1);
    @(negedge clk);
    check_bus("fetch1.bus", 32'h4, 1'b0, 4'hF, 1'b0, '0);
    chk("fetch1.stall_c1", {31'b0, stallreq_if}, 32'd1);
    check_ack("fetch1", 1);
    chk("fetch1.stall_c2", {31'b0, stallreq_if}, 32'd0);
    i_ce = 1'b0;
    @(negedge clk);

    // Simultaneous fetch and data read: data first, one dead cycle, then fetch
    i_ce = 1'b1; i_addr = 32'h8;
    d_ce = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_sel = 4'hF;
    bus_data_q.push_back(32'hDEAD_BEEF);
    bus_data_q.push_back(32'h1234_5678);
    exp_q.push_back('{is_d: 1'b1, data: 32'hDEAD_BEEF});
    exp_q.push_back('{is_d: 1'b0, data: 32'h1234_5678});
    #1 chk("simul.stalls", {30'b0, stallreq_if, stallreq_mem}, 32'd3);
    @(negedge clk);
    check_bus("simul.dbus", 32'h100, 1'b0, 4'hF, 1'b0, '0);
    check_ack("simul.d", 1);
    chk("simul.dead", {31'b0, bus_req}, 32'd0);
    d_ce = 1'b0;
    @(negedge clk);
    check_bus("simul.ibus", 32'h8, 1'b0, 4'hF, 1'b0, '0);
    check_ack("simul.i", 1);
    i_ce = 1'b0;
    @(negedge clk);

    // Write with wait states: fields stable, d_rdata untouched
    wait_cycles = 2;
    d_ce = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hA5A5_A5A5; d_sel = 4'b0011;
    bus_data_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back('{is_d: 1'b1, data: 32'hDEAD_BEEF});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bus("write.bus", 32'h200, 1'b1, 4'b0011, 1'b1, 32'hA5A5_A5A5);
      chk("write.stall", {31'b0, stallreq_mem}, 32'd1);
    end
    check_ack("write", 1);
    chk("write.stall_ack", {31'b0, stallreq_mem}, 32'd0);
    d_ce = 1'b0; d_we = 1'b0;
    settle();

    // Flush mid-fetch: discard, then a normal fetch
    base_i = n_iack;
    i_ce = 1'b1; i_addr = 32'hC;
    bus_data_q.push_back(32'hBAD0_0001);
    @(negedge clk);
    check_bus("flush.bus1", 32'hC, 1'b0, 4'hF, 1'b0, '0);
    @(negedge clk);
    check_bus("flush.bus2", 32'hC, 1'b0, 4'hF, 1'b0, '0);
    flush = 1'b1; i_ce = 1'b0;
    #1 chk("flush.stall", {31'b0, stallreq_if}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    check_bus("flush.discard", 32'hC, 1'b0, 4'hF, 1'b0, '0);
    @(negedge clk);
    chk("flush.req_drop", {31'b0, bus_req}, 32'd0);
    chk("flush.no_ack", {31'b0, i_ack}, 32'd0);
    chk("flush.inst_kept", i_inst, 32'h1234_5678);
    wait_cycles = 0;
    i_ce = 1'b1; i_addr = 32'h20;
    bus_data_q.push_back(32'h0000_ABCD);
    exp_q.push_back('{is_d: 1'b0, data: 32'h0000_ABCD});
    @(negedge clk);
    check_bus("flush.next", 32'h20, 1'b0, 4'hF, 1'b0, '0);
    check_ack("flush.next", 1);
    i_ce = 1'b0;
    settle();
    chk("flush.iack_count", n_iack - base_i, 32'd1);

    // Flush coincident with bus_ack in I_BUSY
    base_i = n_iack;
    i_ce = 1'b1; i_addr = 32'h30;
    bus_data_q.push_back(32'h0000_0055);
    @(negedge clk);
    check_bus("flushack.bus", 32'h30, 1'b0, 4'hF, 1'b0, '0);
    flush = 1'b1; i_ce = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("flushack.no_ack", {31'b0, i_ack}, 32'd0);
    chk("flushack.req", {31'b0, bus_req}, 32'd0);
    chk("flushack.inst_kept", i_inst, 32'h0000_ABCD);
    settle();
    chk("flushack.iack_count", n_iack - base_i, 32'd0);

    // Flush during D_BUSY is ignored
    wait_cycles = 1;
    d_ce = 1'b1; d_we = 1'b0; d_addr = 32'h104; d_sel = 4'hF;
    bus_data_q.push_back(32'hCAFE_F00D);
    exp_q.push_back('{is_d: 1'b1, data: 32'hCAFE_F00D});
    @(negedge clk);
    check_bus("dflush.bus", 32'h104, 1'b0, 4'hF, 1'b0, '0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_ack("dflush", 1);
    d_ce = 1'b0;
    settle();

    // Asynchronous reset in the middle of D_BUSY
    base_i = n_iack;
    base_d = n_dack;
    wait_cycles = 5;
    d_ce = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h0000_0011; d_sel = 4'hF;
    @(negedge clk);
    check_bus("rstmid.bus", 32'h300, 1'b1, 4'hF, 1'b1, 32'h0000_0011);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("rstmid");
    d_ce = 1'b0; d_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rstmid.no_ack", {n_iack - base_i, n_dack - base_d} == 64'd0 ? 32'd0 : 32'd1, 32'd0);
    chk("rstmid.req_idle", {31'b0, bus_req}, 32'd0);

    // Post-reset fetch starts from IDLE with minimum latency
    wait_cycles = 0;
    i_ce = 1'b1; i_addr = 32'h40;
    bus_data_q.push_back(32'h0BAD_F00D);
    exp_q.push_back('{is_d: 1'b0, data: 32'h0BAD_F00D});
    @(negedge clk);
    check_bus("postrst.bus", 32'h40, 1'b0, 4'hF, 1'b0, '0);
    check_ack("postrst", 1);
    i_ce = 1'b0;
    settle();

    chk("sb.empty", exp_q.size(), 32'd0);
    chk("busq.empty", bus_data_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
